sync_ram_be: RTL



---
 rtl/sync_ram_be.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sync_ram_be.sv
// sync_ram_be: parametrised single-port synchronous RAM with per-byte write
// enables, selectable read-during-write behaviour, an optional second output
// register, a read-valid strobe and a zero-fill sweep that runs after reset.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         access request, sampled at posedge clk
//   we         1 = write, 0 = read (qualified by en)
//   be         byte write enables, bit i selects din[8i+7:8i]
//   addr       word address
//   din        write data
//   dout       read data, held whenever dout_valid is low
//   dout_valid one-cycle strobe marking new dout
//   busy       clear sweep in progress; accesses are ignored while high
//
// Handshake: an access is accepted on a rising edge where en = 1 and busy = 0.
// There is no backpressure; one access per cycle is always accepted once ready.
// dout_valid pulses for exactly one cycle per accepted access that produces
// data (every read; writes except in NO_CHANGE mode), 1 cycle after the
// accepting edge with OUT_REG = 0 and 2 cycles after it with OUT_REG = 1.
module sync_ram_be #(
    parameter int DATA_W        = 8,
    parameter int ADDR_W        = 4,
    parameter int DEPTH         = 16,
    parameter int RDW_MODE      = 0,
    parameter int OUT_REG       = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   din,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_valid,
    output logic                busy
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {SWEEP, READY} state_t;
    localparam state_t RST_STATE = (INIT_ON_RESET != 0) ? SWEEP : READY;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                in_range;
    logic [DATA_W-1:0]   old_word;
    logic [DATA_W-1:0]   merged;
    logic [DATA_W-1:0]   d1_q;
    logic                v1_q;

    // ---------------- clear-sweep FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    assign busy = (state_q == SWEEP);

    // ---------------- access decode ----------------
    assign accept   = en && !busy;
    assign in_range = ({1'b0, addr} < DEPTH_L);
    // Out-of-range reads return zero rather than an aliased word.
    assign old_word = in_range ? mem[addr[IDX_W-1:0]] : '0;

    always_comb begin
        merged = old_word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) merged[i*8 +: 8] = din[i*8 +: 8];
        end
    end

    // Memory array has no reset; only the sweep and accepted writes touch it.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt_q[IDX_W-1:0]] <= '0;
        end else if (accept && we && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[addr[IDX_W-1:0]][i*8 +: 8] <= din[i*8 +: 8];
            end
        end
    end

    // ---------------- first output stage ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d1_q <= '0;
            v1_q <= 1'b0;
        end else begin
            v1_q <= 1'b0;
            if (accept) begin
                if (!we) begin
                    d1_q <= old_word;
                    v1_q <= 1'b1;
                end else if (RDW_MODE == 0) begin
                    d1_q <= old_word;
                    v1_q <= 1'b1;
                end else if (RDW_MODE == 1) begin
                    // A dropped out-of-range write leaves memory reading zero.
                    d1_q <= in_range ? merged : '0;
                    v1_q <= 1'b1;
                end
                // NO_CHANGE: dout holds and no strobe is emitted.
            end
        end
    end

    // ---------------- optional second output stage ----------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] d2_q;
            logic              v2_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    d2_q <= '0;
                    v2_q <= 1'b0;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q) d2_q <= d1_q;
                end
            end
            assign dout       = d2_q;
            assign dout_valid = v2_q;
        end else begin : g_no_out_reg
            assign dout       = d1_q;
            assign dout_valid = v1_q;
        end
    endgenerate

endmodule
